// File: rtl/vec_chunk_fifo.sv
// Chunked-vector buffer: producer writes WorkingRegs-wide int8 chunks, consumer
// pulls them one per rd_req with a one-cycle registered read and whole-vector tracking.
module vec_chunk_fifo #(
  parameter int unsigned VecLength   = 12,
  parameter int unsigned WorkingRegs = 3,
  parameter int unsigned Depth       = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                wr_en,
  input  logic signed [WorkingRegs-1:0][7:0]  wr_data,
  input  logic                                rd_req,
  input  logic                                flush,
  output logic signed [WorkingRegs-1:0][7:0]  rd_data,
  output logic                                rd_valid,
  output logic                                vec_ready,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(Depth+1)-1:0]          vec_count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned CPV     = VecLength / WorkingRegs;
  localparam int unsigned ENTRIES = Depth * CPV;
  localparam int unsigned DATA_W  = 8 * WorkingRegs;
  localparam int unsigned PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned SUB_W   = (CPV > 1) ? $clog2(CPV) : 1;
  localparam int unsigned CNT_W   = $clog2(ENTRIES + 1);
  localparam int unsigned VC_W    = $clog2(Depth + 1);

  logic [DATA_W-1:0] mem_q [ENTRIES];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SUB_W-1:0]  wr_sub_q, wr_sub_d;
  logic [SUB_W-1:0]  rd_sub_q, rd_sub_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [VC_W-1:0]   vec_count_q, vec_count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              vec_ready_q, vec_ready_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic rd_acc_c, wr_acc_c, mem_we_c, vec_done_c, vec_fin_c;

  // Handshake decode; a full buffer still takes a write when a read frees a slot.
  always_comb begin
    rd_acc_c   = rd_req && !empty_q;
    wr_acc_c   = wr_en && (!full_q || rd_acc_c);
    mem_we_c   = wr_acc_c && !flush;
    vec_done_c = wr_acc_c && (wr_sub_q == SUB_W'(CPV - 1));
    vec_fin_c  = rd_acc_c && (rd_sub_q == SUB_W'(CPV - 1));
  end

  // Next-state for pointers, counters, flags and the read register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_sub_d    = wr_sub_q;
    rd_sub_d    = rd_sub_q;
    count_d     = count_q;
    vec_count_d = vec_count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      wr_sub_d    = '0;
      rd_sub_d    = '0;
      count_d     = '0;
      vec_count_d = '0;
      rd_data_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        wr_sub_d = vec_done_c ? '0 : wr_sub_q + SUB_W'(1);
      end else if (wr_en) begin
        overflow_d = 1'b1;
      end

      if (rd_acc_c) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = (rd_ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        rd_sub_d   = vec_fin_c ? '0 : rd_sub_q + SUB_W'(1);
      end else if (rd_req) begin
        underflow_d = 1'b1;
      end

      unique case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      if (vec_done_c && !vec_fin_c) begin
        vec_count_d = vec_count_q + VC_W'(1);
      end else if (vec_fin_c && !vec_done_c) begin
        vec_count_d = vec_count_q - VC_W'(1);
      end
    end

    full_d      = (count_d == CNT_W'(ENTRIES));
    empty_d     = (count_d == '0);
    vec_ready_d = (vec_count_d != '0);
  end

  // Control and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_sub_q    <= '0;
      rd_sub_q    <= '0;
      count_q     <= '0;
      vec_count_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      vec_ready_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_sub_q    <= wr_sub_d;
      rd_sub_q    <= rd_sub_d;
      count_q     <= count_d;
      vec_count_q <= vec_count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      vec_ready_q <= vec_ready_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Chunk storage; contents are never reset.
  always_ff @(posedge clk_in) begin
    if (mem_we_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign vec_ready = vec_ready_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign vec_count = vec_count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// Directed bench for vec_chunk_fifo at default parameters (CPV=4, ENTRIES=8).
module tb_vec_chunk_fifo;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic                   wr_en  = 1'b0;
  logic                   rd_req = 1'b0;
  logic                   flush  = 1'b0;
  logic signed [2:0][7:0] wr_data = '0;
  logic signed [2:0][7:0] rd_data;
  logic                   rd_valid, vec_ready, full, empty, overflow, underflow;
  logic [1:0]             vec_count;

  int n_vec = 0;
  int n_err = 0;

  vec_chunk_fifo #(.VecLength(12), .WorkingRegs(3), .Depth(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data),
    .rd_req(rd_req), .flush(flush), .rd_data(rd_data), .rd_valid(rd_valid),
    .vec_ready(vec_ready), .full(full), .empty(empty), .vec_count(vec_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [23:0] mk(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [23:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full); end
    n_vec++; if (vec_count !== 2'd0) begin n_err++; $display("FAIL rst_vec_count got %0d want 0", vec_count); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
    n_vec++; if (rd_data !== 24'h0) begin n_err++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
    n_vec++; if ({overflow, underflow, vec_ready} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {overflow, underflow, vec_ready}); end
    rst_in = 1'b0;
    cyc();
    // mid-stream asynchronous reset with a read pulse in flight
    push(mk(1, 1, 1));
    push(mk(2, 2, 2));
    push(mk(3, 3, 3));
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_rd_valid got %b want 1", rd_valid); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL pre_rst_empty got %b want 0", empty); end
    #2;
    rst_in = 1'b1;
    #1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL async_rst_empty got %b want 1", empty); end
    n_vec++; if (vec_count !== 2'd0) begin n_err++; $display("FAIL async_rst_vec_count got %0d want 0", vec_count); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_rd_valid got %b want 0", rd_valid); end
    rst_in = 1'b0;
    cyc();
  endtask

  task automatic test_fill_drain();
    push(mk(1, 2, 3));
    push(mk(4, 5, 6));
    push(mk(7, 8, 9));
    n_vec++; if (vec_ready !== 1'b0) begin n_err++; $display("FAIL fd_partial_ready got %b want 0", vec_ready); end
    push(mk(10, 11, 12));
    n_vec++; if (vec_ready !== 1'b1) begin n_err++; $display("FAIL fd_ready got %b want 1", vec_ready); end
    n_vec++; if (vec_count !== 2'd1) begin n_err++; $display("FAIL fd_vec_count got %0d want 1", vec_count); end
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++; if (rd_data !== mk(3*k+1, 3*k+2, 3*k+3)) begin n_err++; $display("FAIL fd_data[%0d] got %h want %h", k, rd_data, mk(3*k+1, 3*k+2, 3*k+3)); end
      n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL fd_valid[%0d] got %b want 1", k, rd_valid); end
    end
    rd_req = 1'b0;
    n_vec++; if (vec_ready !== 1'b0) begin n_err++; $display("FAIL fd_ready_drop got %b want 0", vec_ready); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fd_empty got %b want 1", empty); end
    cyc();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fd_valid_idle got %b want 0", rd_valid); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) push(mk(i+20, i+40, -i));
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ov_full got %b want 1", full); end
    n_vec++; if (vec_count !== 2'd2) begin n_err++; $display("FAIL ov_vec_count got %0d want 2", vec_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ov_pre got %b want 0", overflow); end
    push(mk(99, 99, 99));
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_set got %b want 1", overflow); end
    n_vec++; if (vec_count !== 2'd2) begin n_err++; $display("FAIL ov_vec_count_hold got %0d want 2", vec_count); end
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_vec++; if (rd_data !== mk(i+20, i+40, -i)) begin n_err++; $display("FAIL ov_data[%0d] got %h want %h", i, rd_data, mk(i+20, i+40, -i)); end
    end
    rd_req = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ov_empty got %b want 1", empty); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_sticky got %b want 1", overflow); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ov_flush_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_concurrent();
    for (int i = 0; i < 8; i++) push(mk(i+60, i+70, i+80));
    wr_en = 1'b1;
    wr_data = mk(-1, -2, -3);
    rd_req = 1'b1;
    cyc();
    wr_en = 1'b0;
    n_vec++; if (rd_data !== mk(60, 70, 80)) begin n_err++; $display("FAIL fc_first got %h want %h", rd_data, mk(60, 70, 80)); end
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fc_full got %b want 1", full); end
    n_vec++; if (vec_count !== 2'd2) begin n_err++; $display("FAIL fc_vec_count got %0d want 2", vec_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fc_no_overflow got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i < 7) begin
        n_vec++; if (rd_data !== mk(i+61, i+71, i+81)) begin n_err++; $display("FAIL fc_data[%0d] got %h want %h", i, rd_data, mk(i+61, i+71, i+81)); end
      end else begin
        n_vec++; if (rd_data !== mk(-1, -2, -3)) begin n_err++; $display("FAIL fc_new got %h want %h", rd_data, mk(-1, -2, -3)); end
      end
    end
    rd_req = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fc_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_pre got %b want 0", underflow); end
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", underflow); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL uf_valid got %b want 0", rd_valid); end
    n_vec++; if (rd_data !== mk(-1, -2, -3)) begin n_err++; $display("FAIL uf_data_hold got %h want %h", rd_data, mk(-1, -2, -3)); end
    // write and read together while empty: write wins, read is rejected
    wr_en = 1'b1;
    wr_data = mk(5, 6, 7);
    rd_req = 1'b1;
    cyc();
    wr_en = 1'b0;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL uf_nobypass_valid got %b want 0", rd_valid); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL uf_write_taken got %b want 0", empty); end
    cyc();
    rd_req = 1'b0;
    n_vec++; if (rd_data !== mk(5, 6, 7)) begin n_err++; $display("FAIL uf_readback got %h want %h", rd_data, mk(5, 6, 7)); end
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL uf_readback_valid got %b want 1", rd_valid); end
  endtask

  task automatic test_vec_boundary();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL vb_flush_uf got %b want 0", underflow); end
    n_vec++; if (rd_data !== 24'h0) begin n_err++; $display("FAIL vb_flush_data got %h want 0", rd_data); end
    for (int i = 1; i <= 7; i++) push(mk(i, i, i));
    n_vec++; if (vec_count !== 2'd1) begin n_err++; $display("FAIL vb_vec_count got %0d want 1", vec_count); end
    rd_req = 1'b1;
    cyc();
    cyc();
    cyc();
    wr_en = 1'b1;
    wr_data = mk(8, 8, 8);
    cyc();
    wr_en = 1'b0;
    n_vec++; if (rd_data !== mk(4, 4, 4)) begin n_err++; $display("FAIL vb_data got %h want %h", rd_data, mk(4, 4, 4)); end
    n_vec++; if (vec_count !== 2'd1) begin n_err++; $display("FAIL vb_same_cycle_count got %0d want 1", vec_count); end
    n_vec++; if (vec_ready !== 1'b1) begin n_err++; $display("FAIL vb_same_cycle_ready got %b want 1", vec_ready); end
    for (int i = 5; i <= 8; i++) begin
      cyc();
      n_vec++; if (rd_data !== mk(i, i, i)) begin n_err++; $display("FAIL vb_drain[%0d] got %h want %h", i, rd_data, mk(i, i, i)); end
    end
    rd_req = 1'b0;
    n_vec++; if (vec_count !== 2'd0) begin n_err++; $display("FAIL vb_final_count got %0d want 0", vec_count); end
  endtask

  task automatic test_flush_priority();
    push(mk(30, 31, 32));
    push(mk(33, 34, 35));
    flush = 1'b1;
    wr_en = 1'b1;
    rd_req = 1'b1;
    wr_data = mk(36, 37, 38);
    cyc();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_req = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fp_empty got %b want 1", empty); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fp_valid got %b want 0", rd_valid); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL fp_flags got %b want 00", {overflow, underflow}); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_overflow();
    test_full_concurrent();
    test_underflow();
    test_vec_boundary();
    test_flush_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
